// File: rtl/id_branch_resolve.sv
// ID-stage control-flow resolver: decodes branches/jumps, computes targets and holds
// hazarding branch/jr instructions in a stall FSM. BRANCH_STATS_EN adds saturating statistics counters.

module id_branch_resolve #(
   parameter int unsigned MAX_STALL = 2
`ifdef BRANCH_STATS_EN
   ,
   parameter int unsigned STAT_W    = 16
`endif
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_valid,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc_plus4,
   input  logic [31:0] i_rs_data,
   input  logic [31:0] i_rt_data,
   input  logic        i_ex_regwrite,
   input  logic        i_ex_memread,
   input  logic [4:0]  i_ex_rd,
   input  logic        i_mem_memread,
   input  logic [4:0]  i_mem_rd,
   output logic [1:0]  o_con_jump,
   output logic        o_con_ifbranch,
   output logic [25:0] o_addr_jump,
   output logic [31:0] o_addr_jumpr,
   output logic [31:0] o_addr_branch,
   output logic        o_flush,
   output logic        o_stall,
   output logic        o_link_we,
   output logic [31:0] o_link_data
`ifdef BRANCH_STATS_EN
   ,
   output logic [STAT_W-1:0] o_stat_taken,
   output logic [STAT_W-1:0] o_stat_nottaken,
   output logic [STAT_W-1:0] o_stat_stall
`endif
);

   localparam int unsigned CNT_W = $clog2(MAX_STALL + 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_BLEZ  = 6'b000110;
   localparam logic [5:0] OP_BGTZ  = 6'b000111;
   localparam logic [5:0] FN_JR    = 6'b001000;
   localparam logic [5:0] FN_JALR  = 6'b001001;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_WAIT   = 2'd1,
      ST_RESUME = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               is_beq, is_bne, is_blez, is_bgtz;
   logic               is_j, is_jal, is_jr, is_jalr;
   logic               is_br, is_jmp, is_jreg;
   logic               br_cond;
   logic [CNT_W-1:0]   rs_need, rt_need, need;
   logic               hazard;
   logic               stall_c, resolve_c;
   logic [31:0]        br_offset;

   // Stall cycles a single source register needs against the EX/MEM producers.
   function automatic logic [CNT_W-1:0] src_need(
      input logic [4:0] r,
      input logic [4:0] ex_rd,
      input logic       ex_rw,
      input logic       ex_mr,
      input logic [4:0] mem_rd,
      input logic       mem_mr
   );
      logic [CNT_W-1:0] n;
      n = '0;
      if (r != 5'd0) begin
         if ((r == mem_rd) && mem_mr)           n = CNT_W'(1);
         if ((r == ex_rd) && ex_rw && !ex_mr)   n = CNT_W'(1);
         if ((r == ex_rd) && ex_mr)             n = CNT_W'(2);
      end
      return n;
   endfunction

   // Instruction decode and branch condition evaluation.
   always_comb begin
      is_beq  = (i_instr[31:26] == OP_BEQ);
      is_bne  = (i_instr[31:26] == OP_BNE);
      is_blez = (i_instr[31:26] == OP_BLEZ);
      is_bgtz = (i_instr[31:26] == OP_BGTZ);
      is_j    = (i_instr[31:26] == OP_J);
      is_jal  = (i_instr[31:26] == OP_JAL);
      is_jr   = (i_instr[31:26] == OP_RTYPE) && (i_instr[5:0] == FN_JR);
      is_jalr = (i_instr[31:26] == OP_RTYPE) && (i_instr[5:0] == FN_JALR);
      is_br   = is_beq | is_bne | is_blez | is_bgtz;
      is_jmp  = is_j | is_jal;
      is_jreg = is_jr | is_jalr;

      br_cond = 1'b0;
      if (is_beq)  br_cond = (i_rs_data == i_rt_data);
      if (is_bne)  br_cond = (i_rs_data != i_rt_data);
      if (is_blez) br_cond = i_rs_data[31] | (i_rs_data == 32'd0);
      if (is_bgtz) br_cond = !i_rs_data[31] && (i_rs_data != 32'd0);
   end

   // Hazard stall requirement: rs always, rt only for the two-register compares.
   always_comb begin
      rs_need = src_need(i_instr[25:21], i_ex_rd, i_ex_regwrite, i_ex_memread,
                         i_mem_rd, i_mem_memread);
      rt_need = '0;
      if (is_beq || is_bne) begin
         rt_need = src_need(i_instr[20:16], i_ex_rd, i_ex_regwrite, i_ex_memread,
                            i_mem_rd, i_mem_memread);
      end
      need   = (rs_need > rt_need) ? rs_need : rt_need;
      hazard = i_valid && (is_br || is_jreg) && (need != '0);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Stall FSM: RUN checks hazards, WAIT counts down, RESUME resolves unconditionally.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stall_c   = 1'b0;
      resolve_c = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (hazard) begin
               stall_c = 1'b1;
               if (need == CNT_W'(1)) begin
                  state_d = ST_RESUME;
               end else begin
                  cnt_d   = need - CNT_W'(1);
                  state_d = ST_WAIT;
               end
            end else begin
               resolve_c = i_valid;
            end
         end
         ST_WAIT: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = ST_RESUME;
         end
         ST_RESUME: begin
            resolve_c = i_valid;
            state_d   = ST_RUN;
         end
         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   assign br_offset = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};

   // Output drive; everything is forced low while reset is asserted.
   always_comb begin
      o_con_jump     = 2'b00;
      o_con_ifbranch = 1'b0;
      o_addr_jump    = '0;
      o_addr_jumpr   = '0;
      o_addr_branch  = '0;
      o_flush        = 1'b0;
      o_stall        = 1'b0;
      o_link_we      = 1'b0;
      o_link_data    = '0;
      if (i_rst_n) begin
         o_addr_jump   = i_instr[25:0];
         o_addr_jumpr  = i_rs_data;
         o_addr_branch = i_pc_plus4 + br_offset;
         o_link_data   = i_pc_plus4 + 32'd4;
         o_stall       = stall_c;
         if (resolve_c) begin
            if (is_jmp) begin
               o_con_jump = 2'b01;
               o_flush    = 1'b1;
               o_link_we  = is_jal;
            end else if (is_jreg) begin
               o_con_jump = 2'b10;
               o_flush    = 1'b1;
               o_link_we  = is_jalr;
            end else if (is_br && br_cond) begin
               o_con_ifbranch = 1'b1;
               o_flush        = 1'b1;
            end
         end
      end
   end

`ifdef BRANCH_STATS_EN
   logic [STAT_W-1:0] taken_q, taken_d;
   logic [STAT_W-1:0] nottaken_q, nottaken_d;
   logic [STAT_W-1:0] stallcnt_q, stallcnt_d;
   logic              taken_inc, nottaken_inc;

   // Saturating event counters.
   always_comb begin
      taken_inc    = i_rst_n && resolve_c && is_br && br_cond;
      nottaken_inc = i_rst_n && resolve_c && is_br && !br_cond;
      taken_d      = taken_q;
      nottaken_d   = nottaken_q;
      stallcnt_d   = stallcnt_q;
      if (taken_inc && (taken_q != '1))       taken_d    = taken_q + STAT_W'(1);
      if (nottaken_inc && (nottaken_q != '1)) nottaken_d = nottaken_q + STAT_W'(1);
      if (o_stall && (stallcnt_q != '1))      stallcnt_d = stallcnt_q + STAT_W'(1);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         taken_q    <= '0;
         nottaken_q <= '0;
         stallcnt_q <= '0;
      end else begin
         taken_q    <= taken_d;
         nottaken_q <= nottaken_d;
         stallcnt_q <= stallcnt_d;
      end
   end

   assign o_stat_taken    = i_rst_n ? taken_q    : '0;
   assign o_stat_nottaken = i_rst_n ? nottaken_q : '0;
   assign o_stat_stall    = i_rst_n ? stallcnt_q : '0;
`endif

endmodule

// File: tb/tb_id_branch_resolve.sv
// Self-checking bench for id_branch_resolve: directed cases plus randomized instructions
// checked against an instruction-level reference model.

module tb_id_branch_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [31:0] instr, pc_plus4, rs_data, rt_data;
   logic        ex_regwrite, ex_memread, mem_memread;
   logic [4:0]  ex_rd, mem_rd;
   logic [1:0]  con_jump;
   logic        con_ifbranch, flush, stall, link_we;
   logic [25:0] addr_jump;
   logic [31:0] addr_jumpr, addr_branch, link_data;
`ifdef BRANCH_STATS_EN
   logic [15:0] stat_taken, stat_nottaken, stat_stall;
   int unsigned m_taken = 0, m_nottaken = 0, m_stall = 0;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_branch_resolve dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_valid        (valid),
      .i_instr        (instr),
      .i_pc_plus4     (pc_plus4),
      .i_rs_data      (rs_data),
      .i_rt_data      (rt_data),
      .i_ex_regwrite  (ex_regwrite),
      .i_ex_memread   (ex_memread),
      .i_ex_rd        (ex_rd),
      .i_mem_memread  (mem_memread),
      .i_mem_rd       (mem_rd),
      .o_con_jump     (con_jump),
      .o_con_ifbranch (con_ifbranch),
      .o_addr_jump    (addr_jump),
      .o_addr_jumpr   (addr_jumpr),
      .o_addr_branch  (addr_branch),
      .o_flush        (flush),
      .o_stall        (stall),
      .o_link_we      (link_we),
      .o_link_data    (link_data)
`ifdef BRANCH_STATS_EN
      ,
      .o_stat_taken    (stat_taken),
      .o_stat_nottaken (stat_nottaken),
      .o_stat_stall    (stat_stall)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: per-instruction stall count and resolve-cycle outputs.
   task automatic model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                        input logic exrw, input logic exmr, input logic [4:0] exrd,
                        input logic memmr, input logic [4:0] memrd,
                        output int n, output logic [1:0] cj, output logic ib,
                        output logic fl, output logic lw, output int br);
      int kind;
      int srcs[$];
      int signed rsv;
      bit taken;
      kind = 0;
      case (ins[31:26])
         6'h04: kind = 1;
         6'h05: kind = 2;
         6'h06: kind = 3;
         6'h07: kind = 4;
         6'h02: kind = 5;
         6'h03: kind = 6;
         6'h00: kind = (ins[5:0] == 6'h08) ? 7 : (ins[5:0] == 6'h09) ? 8 : 0;
         default: kind = 0;
      endcase
      rsv   = $signed(rs);
      taken = (kind == 1 && rs == rt) || (kind == 2 && rs != rt) ||
              (kind == 3 && rsv <= 0) || (kind == 4 && rsv > 0);
      if (kind == 1 || kind == 2) srcs = '{int'(ins[25:21]), int'(ins[20:16])};
      else if (kind == 3 || kind == 4 || kind == 7 || kind == 8) srcs = '{int'(ins[25:21])};
      n = 0;
      foreach (srcs[i]) begin
         if (srcs[i] != 0) begin
            if (srcs[i] == int'(exrd) && exmr) n = 2;
            else if (srcs[i] == int'(exrd) && exrw && n < 1) n = 1;
            if (srcs[i] == int'(memrd) && memmr && n < 1) n = 1;
         end
      end
      cj = 2'b00; ib = 1'b0; fl = 1'b0; lw = 1'b0; br = -1;
      if (kind == 5 || kind == 6) begin
         cj = 2'b01; fl = 1'b1; lw = (kind == 6);
      end else if (kind == 7 || kind == 8) begin
         cj = 2'b10; fl = 1'b1; lw = (kind == 8);
      end else if (kind >= 1 && kind <= 4) begin
         ib = taken; fl = taken; br = taken ? 1 : 0;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_ctl"}, 32'({con_jump, con_ifbranch, flush, link_we}), 32'd0);
      chk({tag, "_addr"}, addr_branch | addr_jumpr | link_data | 32'(addr_jump), 32'd0);
   endtask

   // Present one valid instruction from the cycle start (#1 after posedge) through resolve.
   task automatic run_instr(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                            input logic [31:0] rs, input logic [31:0] rt,
                            input logic exrw, input logic exmr, input logic [4:0] exrd,
                            input logic memmr, input logic [4:0] memrd, input bit scramble);
      int n, br;
      logic [1:0] cj;
      logic ib, fl, lw;
      int signed off;
      model(ins, rs, rt, exrw, exmr, exrd, memmr, memrd, n, cj, ib, fl, lw, br);
      valid = 1'b1; instr = ins; pc_plus4 = pc; rs_data = rs; rt_data = rt;
      ex_regwrite = exrw; ex_memread = exmr; ex_rd = exrd;
      mem_memread = memmr; mem_rd = memrd;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
`ifdef BRANCH_STATS_EN
         if (k == 0) begin
            chk({tag, "_stat_taken"}, 32'(stat_taken), m_taken);
            chk({tag, "_stat_nt"}, 32'(stat_nottaken), m_nottaken);
            chk({tag, "_stat_stall"}, 32'(stat_stall), m_stall);
         end
`endif
         chk({tag, "_stall_hold"}, 32'(stall), 32'd1);
         chk({tag, "_stall_noredir"}, 32'({con_jump, con_ifbranch, flush, link_we}), 32'd0);
         @(posedge clk); #1;
`ifdef BRANCH_STATS_EN
         if (m_stall < 65535) m_stall++;
`endif
         if (scramble) begin
            ex_regwrite = 1'($urandom); ex_memread = 1'($urandom); ex_rd = 5'($urandom_range(0, 3));
            mem_memread = 1'($urandom); mem_rd = 5'($urandom_range(0, 3));
         end
      end
      @(negedge clk);
      off = $signed(ins[15:0]);
      chk({tag, "_stall"}, 32'(stall), 32'd0);
      chk({tag, "_con_jump"}, 32'(con_jump), 32'(cj));
      chk({tag, "_ifbranch"}, 32'(con_ifbranch), 32'(ib));
      chk({tag, "_flush"}, 32'(flush), 32'(fl));
      chk({tag, "_link_we"}, 32'(link_we), 32'(lw));
      chk({tag, "_addr_branch"}, addr_branch, pc + 32'(off * 4));
      chk({tag, "_addr_jump"}, 32'(addr_jump), ins & 32'h03FF_FFFF);
      chk({tag, "_addr_jumpr"}, addr_jumpr, rs);
      chk({tag, "_link_data"}, link_data, pc + 32'd4);
`ifdef BRANCH_STATS_EN
      if (n == 0) begin
         chk({tag, "_stat_taken"}, 32'(stat_taken), m_taken);
         chk({tag, "_stat_stall"}, 32'(stat_stall), m_stall);
      end
`endif
      @(posedge clk); #1;
`ifdef BRANCH_STATS_EN
      if (br == 1 && m_taken < 65535) m_taken++;
      if (br == 0 && m_nottaken < 65535) m_nottaken++;
`endif
   endtask

   initial begin
      logic [31:0] ins, rs, rt;
      int kind;
      logic [4:0] rsf, rtf;

      // Reset with a jal presented: everything low.
      rst_n = 1'b0; valid = 1'b1; instr = {6'b000011, 26'h0000040}; pc_plus4 = 32'h200;
      rs_data = 32'h1234; rt_data = 32'h5678; ex_regwrite = 1'b0; ex_memread = 1'b0;
      ex_rd = 5'd0; mem_memread = 1'b0; mem_rd = 5'd0;
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
`ifdef BRANCH_STATS_EN
      @(negedge clk);
      chk("reset_stat_taken", 32'(stat_taken), 32'd0);
      chk("reset_stat_nt", 32'(stat_nottaken), 32'd0);
      chk("reset_stat_stall", 32'(stat_stall), 32'd0);
      valid = 1'b0;
      @(posedge clk); #1;
`endif

      // Directed branch cases.
      run_instr("beq_taken", {6'b000100, 5'd1, 5'd2, 16'h0004}, 32'h100, 32'h5, 32'h5,
                1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      run_instr("bne_eq", {6'b000101, 5'd1, 5'd2, 16'hFFFC}, 32'h100, 32'h7, 32'h7,
                1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      run_instr("bgtz_neg", {6'b000111, 5'd3, 5'd0, 16'h0010}, 32'h300, 32'hFFFF_FFFF, 32'h0,
                1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      run_instr("blez_zero", {6'b000110, 5'd3, 5'd0, 16'h8000}, 32'h0000_0010, 32'h0, 32'h0,
                1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);

      // Jumps, including j with a load hazard on the aliased register field.
      run_instr("jal", {6'b000011, 26'h0000040}, 32'h200, 32'h0, 32'h0,
                1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      run_instr("j_nostall", {6'b000010, 26'h3FF0040}, 32'h400, 32'h9, 32'h9,
                1'b1, 1'b1, 5'd31, 1'b1, 5'd31, 1'b0);

      // jr hazards: EX load (2), EX ALU (1), $0 (none), MEM load on jalr (1).
      run_instr("jr_exload", {6'b000000, 5'd8, 15'd0, 6'b001000}, 32'h500, 32'hDEAD_BEE0, 32'h0,
                1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
      run_instr("jr_exalu", {6'b000000, 5'd8, 15'd0, 6'b001000}, 32'h500, 32'hCAFE_0000, 32'h0,
                1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
      run_instr("jr_r0", {6'b000000, 5'd0, 15'd0, 6'b001000}, 32'h500, 32'h0, 32'h0,
                1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
      run_instr("jalr_memload", {6'b000000, 5'd9, 5'd0, 5'd31, 5'd0, 6'b001001}, 32'h600,
                32'h0000_1000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);

      // Invalid slot: no control outputs even with a hazarding jr.
      valid = 1'b0; instr = {6'b000000, 5'd8, 15'd0, 6'b001000};
      ex_regwrite = 1'b1; ex_memread = 1'b1; ex_rd = 5'd8;
      @(negedge clk);
      chk("invalid_stall", 32'(stall), 32'd0);
      chk("invalid_ctl", 32'({con_jump, con_ifbranch, flush, link_we}), 32'd0);
      @(posedge clk); #1;

      // Reset during WAIT abandons the stall.
      valid = 1'b1;
      @(negedge clk);
      chk("rstwait_run_stall", 32'(stall), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("rstwait_reset");
      @(posedge clk); #1;
      rst_n = 1'b1; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
`ifdef BRANCH_STATS_EN
      m_taken = 0; m_nottaken = 0; m_stall = 0;
`endif
      @(negedge clk);
      chk("rstwait_after_stall", 32'(stall), 32'd0);
      chk("rstwait_after_cj", 32'(con_jump), 32'd2);
      @(posedge clk); #1;

      // Randomized instructions with random hazards, scrambled during stall cycles.
      for (int t = 0; t < 400; t++) begin
         kind = $urandom_range(0, 8);
         rsf  = 5'($urandom_range(0, 3));
         rtf  = 5'($urandom_range(0, 3));
         case (kind)
            1: ins = {6'b000100, rsf, rtf, 16'($urandom)};
            2: ins = {6'b000101, rsf, rtf, 16'($urandom)};
            3: ins = {6'b000110, rsf, rtf, 16'($urandom)};
            4: ins = {6'b000111, rsf, rtf, 16'($urandom)};
            5: ins = {6'b000010, 26'($urandom)};
            6: ins = {6'b000011, 26'($urandom)};
            7: ins = {6'b000000, rsf, 15'($urandom), 6'b001000};
            8: ins = {6'b000000, rsf, 15'($urandom), 6'b001001};
            default: ins = ($urandom_range(0, 1) == 1) ? {6'b100011, rsf, rtf, 16'($urandom)}
                                                       : {6'b000000, rsf, rtf, 11'($urandom), 5'b0};
         endcase
         case ($urandom_range(0, 3))
            0: rs = 32'd0;
            1: rs = 32'h8000_0000 | $urandom;
            default: rs = $urandom;
         endcase
         rt = ($urandom_range(0, 1) == 1) ? rs : $urandom;
         if (kind == 0 && ins[31:26] == 6'b000000) ins[5:0] = 6'b100000;
         run_instr("rand", ins, $urandom, rs, rt, 1'($urandom), 1'($urandom),
                   5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'b1);
      end

`ifdef BRANCH_STATS_EN
      // Drive taken branches until the counter must have saturated.
      valid = 1'b1; instr = {6'b000100, 5'd1, 5'd1, 16'h0001}; rs_data = 32'h1; rt_data = 32'h1;
      ex_regwrite = 1'b0; ex_memread = 1'b0; mem_memread = 1'b0;
      for (int c = 0; c < 65540; c++) @(posedge clk);
      #1;
      @(negedge clk);
      chk("stat_taken_sat", 32'(stat_taken), 32'h0000_FFFF);
      chk("stat_nt_hold", 32'(stat_nottaken), m_nottaken);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_branch_resolve.md
Name: id_branch_resolve

Overview:
- ID-stage control-flow resolver. Decodes the instruction held in IF/ID, compares its register operands, and computes the branch, jump and jump-register targets.
- Drives the IF next-PC mux select (con_jump, con_ifbranch) and its target addresses, plus IF/ID flush and pipeline stall.
- Owns a stall FSM that holds a branch or jr until any hazarding producer in EX/MEM has cleared.

Parameters:
- MAX_STALL, 2, largest stall count the counter must hold (load in EX gives 2 cycles).
- STAT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_valid  in  1  IF/ID holds a valid instruction.
- i_instr  in  32  instruction in ID.
- i_pc_plus4  in  32  PC+4 of the ID instruction.
- i_rs_data  in  32  register file value for rs (instr[25:21]).
- i_rt_data  in  32  register file value for rt (instr[20:16]).
- i_ex_regwrite  in  1  EX instruction writes a register.
- i_ex_memread  in  1  EX instruction is a load.
- i_ex_rd  in  5  EX destination register.
- i_mem_memread  in  1  MEM instruction is a load.
- i_mem_rd  in  5  MEM destination register.
- o_con_jump  out  2  00 none, 01 j/jal, 10 jr/jalr; 11 never driven.
- o_con_ifbranch  out  1  conditional branch taken.
- o_addr_jump  out  26  i_instr[25:0], raw; the mux zero-extends it.
- o_addr_jumpr  out  32  i_rs_data.
- o_addr_branch  out  32  i_pc_plus4 + (sign_ext(instr[15:0]) << 2), modulo 2^32.
- o_flush  out  1  kill the IF/ID instruction on redirect.
- o_stall  out  1  hold PC and IF/ID.
- o_link_we  out  1  jal/jalr link write.
- o_link_data  out  32  i_pc_plus4 + 4.

Behaviour:
- Decoded as control flow:
  - beq 000100, bne 000101, blez 000110, bgtz 000111.
  - j 000010, jal 000011.
  - R-type 000000 with funct jr 001000 or jalr 001001.
  - All other encodings produce no redirect, no stall and no link.
- Branch conditions:
  - beq: rs==rt.
  - bne: rs!=rt.
  - blez: signed rs<=0.
  - bgtz: signed rs>0.
- Address outputs o_addr_* are always computed combinationally; the selects decide their use.
- Output rules:
  - o_con_ifbranch=1 only when o_con_jump=00.
  - o_flush=1 exactly in a cycle where a redirect is issued (taken branch, j/jal, jr/jalr).
  - o_link_we=1 in the resolve cycle of jal/jalr.
- Hazards apply to branch and jr/jalr only (j/jal never stall). A hazard means a source register (rs; rt also for beq/bne) is nonzero and matches a pending producer. Required stall count n is the maximum of:
  - 2 if it matches i_ex_rd with i_ex_memread=1.
  - 1 if it matches i_ex_rd with i_ex_regwrite=1 and i_ex_memread=0.
  - 1 if it matches i_mem_rd with i_mem_memread=1.
- FSM states: RUN, WAIT, RESUME; 2-bit counter cnt.
  - RUN, i_valid=1, hazard with count n:
    - o_stall=1 and no redirect in this cycle.
    - n==1: next state RESUME.
    - n==2: cnt<=1 and next state WAIT.
  - RUN, no hazard: resolve combinationally in the same cycle.
  - WAIT: o_stall=1 and no redirect; the hazard is not re-evaluated; cnt decrements. When cnt==1, next state is RESUME.
  - RESUME: resolve without a hazard check (o_stall=0), then return to RUN.
- Total stall cycles for an instruction equal n; the redirect appears in the first cycle after them.
- i_valid=0 in RUN gives all control outputs 0. i_valid dropping during WAIT/RESUME does not occur by contract, since the pipeline is held.
- Reset:
  - While i_rst_n=0, all outputs are driven 0.
  - On the clock edge: state<=RUN, cnt<=0.
  - Reset mid-WAIT abandons the stall; o_stall is 0 from the reset cycle onward.

Optional Feature:
- BRANCH_STATS_EN defined adds three outputs, each STAT_W wide, saturating at all-ones and cleared by reset:
  - o_stat_taken: +1 per resolved taken branch.
  - o_stat_nottaken: +1 per resolved not-taken branch.
  - o_stat_stall: +1 per cycle with o_stall=1.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- beq, rs=rt=0x5, imm=0x0004, pc_plus4=0x100, no hazard -> same cycle ifbranch=1, con_jump=00, addr_branch=0x110, flush=1, stall=0.
- bne, rs=rt=0x7 -> ifbranch=0, flush=0; bgtz rs=0xFFFFFFFF -> not taken; blez rs=0 -> taken.
- jal, instr[25:0]=0x0000040, pc_plus4=0x200 -> con_jump=01, addr_jump=0x40, link_we=1, link_data=0x204, flush=1; j never stalls even with an EX load to $31.
- jr $8 with EX load writing $8 -> stall=1 for 2 cycles (RUN, WAIT), then RESUME with con_jump=10, addr_jumpr=rs, flush=1. The same case with an EX ALU write gives a 1-cycle stall. An EX write to $0 gives no stall.
- Reset asserted in the WAIT cycle -> outputs 0, next cycle RUN with stall=0; with BRANCH_STATS_EN, counters read 0 and saturate at 0xFFFF after forced overflow.
